// File: rtl/wallace_pkg.sv
// Shared constants and reduction-depth helpers for the pipelined Wallace multiplier.
// WALLACE_MULT_SIGNED_EN adds one Baugh-Wooley constant row to the partial-product count.
package wallace_pkg;

   localparam int unsigned STAGES    = 3;
   localparam int unsigned CSA_MAX_W = 64;

   typedef struct packed {
      logic [CSA_MAX_W-1:0] sum;
      logic [CSA_MAX_W-1:0] carry;
   } csa_pair_t;

   function automatic int unsigned pp_rows(input int unsigned w);
`ifdef WALLACE_MULT_SIGNED_EN
      return w + 1;
`else
      return w;
`endif
   endfunction

   // Row count entering level lvl; each 3:2 level maps r rows to 2*(r/3) + r%3.
   function automatic int unsigned rows_after(input int unsigned w, input int unsigned lvl);
      int unsigned r;
      r = pp_rows(w);
      for (int unsigned i = 0; i < lvl; i++)
         if (r > 2) r = 2 * (r / 3) + r % 3;
      return r;
   endfunction

   function automatic int unsigned tree_levels(input int unsigned w);
      int unsigned r;
      int unsigned n;
      r = pp_rows(w);
      n = 0;
      while (r > 2) begin
         r = 2 * (r / 3) + r % 3;
         n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// One 3:2 carry-save compression level: a row of full-adder cells.
// The carry output is pre-shifted one column left; the carry out of the top bit is dropped.
module wallace_csa_row #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign sum[i] = x[i] ^ y[i] ^ c[i];
      if (i + 1 < W) begin : g_cy
         assign carry[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
      end
   end

endmodule

// File: rtl/wallace_mult_pipe.sv
// 3-stage pipelined Wallace-tree multiplier (W x W -> 2W) with valid/ready and a sideband tag.
// Define WALLACE_MULT_SIGNED_EN to add the sgn port and Baugh-Wooley two's-complement mode.
module wallace_mult_pipe
   import wallace_pkg::*;
#(
   parameter int unsigned W     = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [TAG_W-1:0] in_tag,
`ifdef WALLACE_MULT_SIGNED_EN
   input  logic             sgn,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   z,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned PW    = 2 * W;
   localparam int unsigned R     = pp_rows(W);
   localparam int unsigned L     = tree_levels(W);
   localparam int unsigned SPLIT = (L + 1) / 2;
   localparam int unsigned R1    = rows_after(W, SPLIT);

   logic             adv;
   logic             v1, v2;
   logic [TAG_W-1:0] t1, t2;
   logic [PW-1:0]    tree [0:L][0:R-1];
   logic [PW-1:0]    s1_q [0:R1-1];
   logic [PW-1:0]    s2_q [0:1];
   logic [PW-1:0]    cpa_sum;
   logic [PW-1:0]    cpa_cy;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar i = 0; i < W; i++) begin : g_pp
      logic [W-1:0] term;
      for (genvar j = 0; j < W; j++) begin : g_term
`ifdef WALLACE_MULT_SIGNED_EN
         if ((i == W - 1) != (j == W - 1)) begin : g_inv
            assign term[j] = (a[j] & b[i]) ^ sgn;
         end else begin : g_pos
            assign term[j] = a[j] & b[i];
         end
`else
         assign term[j] = a[j] & b[i];
`endif
      end
      assign tree[0][i] = {{W{1'b0}}, term} << i;
   end

`ifdef WALLACE_MULT_SIGNED_EN
   logic [PW-1:0] bw_const;
   always_comb begin
      bw_const       = '0;
      bw_const[W]    = sgn;
      bw_const[PW-1] = sgn;
   end
   assign tree[0][W] = bw_const;
`endif

   // Level SPLIT reads the S1 register instead of the combinational tree, cutting the tree in two.
   for (genvar lv = 0; lv < L; lv++) begin : g_lvl
      localparam int unsigned N_IN = rows_after(W, lv);
      localparam int unsigned G    = N_IN / 3;
      logic [PW-1:0] src [0:N_IN-1];

      for (genvar r = 0; r < N_IN; r++) begin : g_src
         if (lv == SPLIT) begin : g_reg
            assign src[r] = s1_q[r];
         end else begin : g_comb
            assign src[r] = tree[lv][r];
         end
      end

      for (genvar k = 0; k < G; k++) begin : g_csa
         wallace_csa_row #(.W(PW)) u_row (
            .x     (src[3*k]),
            .y     (src[3*k+1]),
            .c     (src[3*k+2]),
            .sum   (tree[lv+1][2*k]),
            .carry (tree[lv+1][2*k+1])
         );
      end

      for (genvar k = 3 * G; k < N_IN; k++) begin : g_pass
         assign tree[lv+1][k-G] = src[k];
      end
   end

   for (genvar r = 0; r < R1; r++) begin : g_s1
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            s1_q[r] <= '0;
         else if (adv)
            s1_q[r] <= tree[SPLIT][r];
      end
   end

   assign cpa_cy[0] = 1'b0;
   for (genvar i = 0; i < PW; i++) begin : g_cpa
      assign cpa_sum[i] = s2_q[0][i] ^ s2_q[1][i] ^ cpa_cy[i];
      if (i + 1 < PW) begin : g_cy
         assign cpa_cy[i+1] = (s2_q[0][i] & s2_q[1][i]) | (cpa_cy[i] & (s2_q[0][i] ^ s2_q[1][i]));
      end
   end

   // z/out_tag only load on a valid S2 entry so they keep the last result across bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         t1        <= '0;
         t2        <= '0;
         s2_q[0]   <= '0;
         s2_q[1]   <= '0;
         z         <= '0;
         out_tag   <= '0;
      end else if (adv) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         t1        <= in_tag;
         t2        <= t1;
         s2_q[0]   <= tree[L][0];
         s2_q[1]   <= tree[L][1];
         if (v2) begin
            z       <= cpa_sum;
            out_tag <= t2;
         end
      end
   end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench for wallace_mult_pipe: directed W=4 cases plus a randomized W=16 stream.
// Build with WALLACE_MULT_SIGNED_EN to also exercise the signed mode.
module tb_wallace_mult_pipe;
   import wallace_pkg::*;

   localparam int NRAND = 10000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        iv4, ir4, ov4, or4, s4;
   logic [3:0]  a4, b4, ti4, to4;
   logic [7:0]  z4;
   logic        iv16, ir16, ov16, or16, s16;
   logic [15:0] a16, b16;
   logic [3:0]  ti16, to16;
   logic [31:0] z16;

   int n_tests = 0;
   int n_fail  = 0;
   int rx4     = 0;
   int rx16    = 0;
   logic done16 = 1'b0;

   typedef struct {
      logic [63:0] z;
      logic [3:0]  tag;
   } exp_t;
   exp_t q4[$];
   exp_t q16[$];

   wallace_mult_pipe #(.W(4), .TAG_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .in_tag(ti4),
`ifdef WALLACE_MULT_SIGNED_EN
      .sgn(s4),
`endif
      .out_valid(ov4), .out_ready(or4), .z(z4), .out_tag(to4)
   );

   wallace_mult_pipe #(.W(16), .TAG_W(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .in_tag(ti16),
`ifdef WALLACE_MULT_SIGNED_EN
      .sgn(s16),
`endif
      .out_valid(ov16), .out_ready(or16), .z(z16), .out_tag(to16)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input logic s, input int w);
      longint sx, sy;
      logic [63:0] mask, p;
      mask = (64'd1 << (2 * w)) - 64'd1;
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
      if (s) begin
         if (x[w-1]) sx = sx - (longint'(1) << w);
         if (y[w-1]) sy = sy - (longint'(1) << w);
      end
      p = 64'(sx * sy);
      return p & mask;
   endfunction

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 7))
         0:       return 16'hFFFF;
         1:       return 16'h0000;
         2:       return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   logic       stall4, stall16;
   logic [7:0] held_z4, last_z4;
   logic [3:0] held_t4, held_t16;
   logic [31:0] held_z16, last_z16;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q4.delete();
         stall4  = 1'b0;
         last_z4 = '0;
      end else begin
         if (stall4) begin
            check("hold_valid4", 64'(ov4), 1);
            check("hold_z4", 64'(z4), 64'(held_z4));
            check("hold_tag4", 64'(to4), 64'(held_t4));
         end
         if (!ov4) check("idle_z4", 64'(z4), 64'(last_z4));
         if (ov4 && or4) begin
            if (q4.size() == 0) check("spurious4", 64'(ov4), 0);
            else begin
               e = q4.pop_front();
               check("z4", 64'(z4), e.z);
               check("tag4", 64'(to4), 64'(e.tag));
            end
            last_z4 = z4;
            rx4++;
         end
         stall4  = ov4 && !or4;
         held_z4 = z4;
         held_t4 = to4;
         if (iv4 && ir4) q4.push_back('{z: ref_mul(32'(a4), 32'(b4), s4, 4), tag: ti4});
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q16.delete();
         stall16  = 1'b0;
         last_z16 = '0;
      end else begin
         if (stall16) begin
            check("hold_valid16", 64'(ov16), 1);
            check("hold_z16", 64'(z16), 64'(held_z16));
            check("hold_tag16", 64'(to16), 64'(held_t16));
         end
         if (!ov16) check("idle_z16", 64'(z16), 64'(last_z16));
         if (ov16 && or16) begin
            if (q16.size() == 0) check("spurious16", 64'(ov16), 0);
            else begin
               e = q16.pop_front();
               check("z16", 64'(z16), e.z);
               check("tag16", 64'(to16), 64'(e.tag));
            end
            last_z16 = z16;
            rx16++;
         end
         stall16  = ov16 && !or16;
         held_z16 = z16;
         held_t16 = to16;
         if (iv16 && ir16) q16.push_back('{z: ref_mul(32'(a16), 32'(b16), s16, 16), tag: ti16});
      end
   end

   task automatic single4(input logic [3:0] x, input logic [3:0] y, input logic s,
                          input logic [7:0] exp);
      int cyc;
      a4 = x; b4 = y; s4 = s; ti4 = x ^ y; iv4 = 1'b1; or4 = 1'b1;
      check("accept4", 64'(ir4), 1);
      @(posedge clk); #1;
      iv4 = 1'b0;
      cyc = 1;
      while (!ov4 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency4", 64'(cyc), 64'(STAGES));
      check("z4_directed", 64'(z4), 64'(exp));
      @(posedge clk); #1;
   endtask

   task automatic send4(input logic [3:0] x, input logic [3:0] y, input logic [3:0] t);
      int n;
      logic ok;
      n = 0;
      a4 = x; b4 = y; ti4 = t; iv4 = 1'b1;
      do begin
         @(negedge clk); ok = ir4;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 50);
      if (!ok) check("send4_timeout", 64'(ok), 1);
      iv4 = 1'b0;
   endtask

   task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic [3:0] t,
                         input logic s);
      int n;
      logic ok;
      n = 0;
      a16 = x; b16 = y; ti16 = t; s16 = s; iv16 = 1'b1;
      do begin
         @(negedge clk); ok = ir16;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 200);
      if (!ok) check("send16_timeout", 64'(ok), 1);
      iv16 = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int rx_before, n;
      rst = 1'b1;
      iv4 = 0; or4 = 1; a4 = 0; b4 = 0; ti4 = 0; s4 = 0;
      iv16 = 0; or16 = 1; a16 = 0; b16 = 0; ti16 = 0; s16 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ov4", 64'(ov4), 0);
      check("rst_z4", 64'(z4), 0);
      check("rst_tag4", 64'(to4), 0);
      check("rst_ov16", 64'(ov16), 0);
      check("rst_z16", 64'(z16), 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 64'(ir4), 1);
      @(posedge clk); #1;

      single4(4'd15, 4'd15, 1'b0, 8'hE1);
      single4(4'd0,  4'd9,  1'b0, 8'h00);
      single4(4'd1,  4'd1,  1'b0, 8'h01);
`ifdef WALLACE_MULT_SIGNED_EN
      single4(4'h8, 4'h8, 1'b1, 8'h40);
      single4(4'h8, 4'h7, 1'b1, 8'hC8);
      single4(4'hF, 4'h1, 1'b1, 8'hFF);
      single4(4'h8, 4'h8, 1'b0, 8'h40);
      s4 = 1'b0;
`endif

      for (int c = 0; c < 13; c++) begin
         if (c < 8) begin
            a4 = 4'($urandom); b4 = 4'($urandom); ti4 = 4'(c); iv4 = 1'b1;
         end else iv4 = 1'b0;
         check("stream_valid", 64'(ov4), 64'(c >= 3 && c < 11));
         if (c >= 3 && c < 11) check("stream_tag", 64'(to4), 64'(c - 3));
         @(posedge clk); #1;
      end

      rx_before = rx4;
      or4 = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send4(4'($urandom), 4'($urandom), 4'(8 + i));
         end
         begin
            repeat (8) begin
               @(negedge clk);
               if (ov4) check("bp_in_ready", 64'(ir4), 0);
            end
            @(posedge clk); #1;
            or4 = 1'b1;
         end
      join
      repeat (10) begin @(posedge clk); #1; end
      check("bp_count", 64'(rx4 - rx_before), 4);

      send4(4'd3, 4'd5, 4'd1);
      send4(4'd7, 4'd7, 4'd2);
      #1 rst = 1'b1;
      #1;
      check("rst_async_ov", 64'(ov4), 0);
      check("rst_async_z", 64'(z4), 0);
      check("rst_async_tag", 64'(to4), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) begin
         check("no_stale", 64'(ov4), 0);
         @(posedge clk); #1;
      end

      send16(16'hFFFF, 16'hFFFF, 4'hA, 1'b0);
      n = 0;
      while (!ov16 && n < 10) begin @(posedge clk); #1; n++; end
      check("z16_ffff", 64'(z16), 64'hFFFE0001);
      @(posedge clk); #1;

      fork
         begin
            for (int i = 0; i < NRAND; i++) begin
               logic [15:0] x, y;
               logic s;
               x = pick16();
               y = pick16();
`ifdef WALLACE_MULT_SIGNED_EN
               s = 1'($urandom_range(0, 1));
`else
               s = 1'b0;
`endif
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               send16(x, y, 4'(i), s);
            end
            done16 = 1'b1;
         end
         begin
            int guard;
            guard = 0;
            while (!(done16 && q16.size() == 0 && !ov16) && guard < 200000) begin
               or16 = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
               guard++;
            end
            or16 = 1'b1;
            if (guard >= 200000) check("rand_timeout", 64'(done16), 64'(guard < 0));
         end
      join

      check("drain4", 64'(q4.size()), 0);
      check("drain16", 64'(q16.size()), 0);
      check("rand_count", 64'(rx16), 64'(NRAND + 1));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
